pc_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the NPC core. It owns the architectural PC and steps each instruction through fetch, execute, optional memory access and write-back over valid/ready handshakes to the instruction fetch unit (IFU) and load/store unit (LSU). It resolves the next PC from the decoder's 3-bit branch code and the ALU `zero`/`less` flags. It gates register-file writes so that each instruction retires exactly once.

---
 rtl/pc_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer for the NPC core.
// Owns the architectural PC, walks each instruction through fetch, execute,
// optional memory access and write-back over IFU/LSU valid/ready handshakes,
// and gates register-file writes so every instruction retires exactly once.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [2:0]  branch,
    input  logic        zero,
    input  logic        less,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        rd_we,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic        ebreak,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        lsu_rsp_ready,
    output logic        reg_we,
    output logic        retire,
    output logic        halted,
    output logic        error
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_IWAIT,
        S_EXEC,
        S_MREQ,
        S_MWAIT,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [2:0] BR_SEQ     = 3'b000;
    localparam logic [2:0] BR_JAL     = 3'b001;
    localparam logic [2:0] BR_JALR    = 3'b010;
    localparam logic [2:0] BR_ILLEGAL = 3'b011;
    localparam logic [2:0] BR_BEQ     = 3'b100;
    localparam logic [2:0] BR_BNE     = 3'b101;
    localparam logic [2:0] BR_BLT     = 3'b110;
    localparam logic [2:0] BR_BGE     = 3'b111;

    state_t      state;
    state_t      state_next;
    logic [31:0] next_pc_q;
    logic        rd_we_q;
    logic [31:0] pc_seq;
    logic [31:0] pc_rel;
    logic [31:0] target_pc;
    logic        bad_branch;

    assign ifu_addr   = pc;
    assign bad_branch = (branch == BR_ILLEGAL);

    // Resolve the successor PC from the branch code and ALU flags; sampled in EXEC
    always_comb begin
        pc_seq    = pc + 32'd4;
        pc_rel    = pc + imm;
        target_pc = pc_seq;
        case (branch)
            BR_SEQ:  target_pc = pc_seq;
            BR_JAL:  target_pc = pc_rel;
            BR_JALR: target_pc = (rs1_val + imm) & ~32'h1;
            BR_BEQ:  target_pc = zero ? pc_rel : pc_seq;
            BR_BNE:  target_pc = zero ? pc_seq : pc_rel;
            BR_BLT:  target_pc = less ? pc_rel : pc_seq;
            BR_BGE:  target_pc = less ? pc_seq : pc_rel;
            default: target_pc = pc_seq;
        endcase
    end

    // Next-state selection and handshake/strobe outputs, all decoded from the state
    always_comb begin
        state_next    = state;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_rsp_ready = 1'b0;
        reg_we        = 1'b0;
        retire        = 1'b0;
        case (state)
            S_RESET: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) begin
                    state_next = S_IWAIT;
                end
            end
            S_IWAIT: begin
                ifu_rsp_ready = 1'b1;
                if (ifu_rsp_valid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ebreak || bad_branch) begin
                    state_next = S_HALT;
                end else if (mem_re || mem_we) begin
                    state_next = S_MREQ;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MREQ: begin
                lsu_req_valid = 1'b1;
                if (lsu_req_ready) begin
                    state_next = S_MWAIT;
                end
            end
            S_MWAIT: begin
                lsu_rsp_ready = 1'b1;
                if (lsu_rsp_valid) begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                reg_we     = rd_we_q;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_RESET;
            end
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Architectural PC, latched instruction, EXEC results and sticky halt/error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            inst      <= 32'h0;
            next_pc_q <= RESET_PC;
            rd_we_q   <= 1'b0;
            halted    <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IWAIT: begin
                    if (ifu_rsp_valid) begin
                        inst <= ifu_rdata;
                    end
                end
                S_EXEC: begin
                    if (ebreak) begin
                        halted <= 1'b1;
                    end else if (bad_branch) begin
                        halted <= 1'b1;
                        error  <= 1'b1;
                    end else begin
                        next_pc_q <= target_pc;
                        rd_we_q   <= rd_we;
                    end
                end
                S_WB: begin
                    pc <= next_pc_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives pc_sequencer as IFU, LSU and decoder at once and
// compares its PC flow, handshakes and retire/write strobes to a small model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid = 1'b0;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  branch = 3'b000;
    logic        zero = 1'b0;
    logic        less = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_val = 32'h0;
    logic        rd_we = 1'b0;
    logic        mem_re = 1'b0;
    logic        mem_we = 1'b0;
    logic        ebreak = 1'b0;
    logic        lsu_req_valid;
    logic        lsu_req_ready = 1'b0;
    logic        lsu_rsp_valid = 1'b0;
    logic        lsu_rsp_ready;
    logic        reg_we;
    logic        retire;
    logic        halted;
    logic        error;

    int          checks = 0;
    int          failures = 0;
    int          retire_cnt = 0;
    logic [31:0] model_pc = RESET_PC;

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rdata     (ifu_rdata),
        .inst          (inst),
        .pc            (pc),
        .branch        (branch),
        .zero          (zero),
        .less          (less),
        .imm           (imm),
        .rs1_val       (rs1_val),
        .rd_we         (rd_we),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .ebreak        (ebreak),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .reg_we        (reg_we),
        .retire        (retire),
        .halted        (halted),
        .error         (error)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count retire pulses on the falling edge, away from state updates
    always @(negedge clk) begin
        if (retire) retire_cnt++;
    end

    // Hard stop in case the sequence itself ever runs away
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] ctrlBits();
        return {ifu_req_valid, ifu_rsp_ready, lsu_req_valid, lsu_rsp_ready,
                reg_we, retire, halted, error};
    endfunction

    // Next PC from the architectural rules: conditional branches compare
    // zero (eq/ne) or less (lt/ge), with the low code bit inverting the test
    function automatic logic [31:0] modelNext(input logic [31:0] cur, input logic [2:0] br,
                                              input logic z, input logic l,
                                              input logic [31:0] im, input logic [31:0] rs1);
        logic flag;
        logic taken;
        if (br == 3'b000) return cur + 32'd4;
        if (br == 3'b001) return cur + im;
        if (br == 3'b010) return (rs1 + im) & 32'hFFFF_FFFE;
        flag  = br[1] ? l : z;
        taken = flag ^ br[0];
        return taken ? cur + im : cur + 32'd4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] br, input logic z, input logic l,
                                 input logic [31:0] im, input logic [31:0] rs1,
                                 input logic rdwe, input logic mre, input logic mwe,
                                 input logic eb);
        branch  = br;
        zero    = z;
        less    = l;
        imm     = im;
        rs1_val = rs1;
        rd_we   = rdwe;
        mem_re  = mre;
        mem_we  = mwe;
        ebreak  = eb;
    endtask

    task automatic doReset();
        stepClk();
        rst_n         = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_ctrl", {24'h0, ctrlBits()}, 32'h0);
        stepClk();
        stepClk();
        rst_n    = 1'b1;
        model_pc = RESET_PC;
        checkOutput("reset_state_ctrl", {24'h0, ctrlBits()}, 32'h0);
        stepClk();
    endtask

    // From FETCH to EXEC: hold off the request and response by the given counts
    task automatic doFetch(input int req_wait, input int rsp_wait,
                           input logic [31:0] word, input bit spurious);
        checkOutput("fetch_valid", {31'h0, ifu_req_valid}, 32'h1);
        checkOutput("fetch_addr", ifu_addr, model_pc);
        ifu_rdata     = $urandom;
        ifu_req_ready = 1'b0;
        for (int i = 0; i < req_wait; i++) begin
            if (spurious) lsu_rsp_valid = 1'b1;
            stepClk();
            checkOutput("fetch_hold_valid", {31'h0, ifu_req_valid}, 32'h1);
            checkOutput("fetch_hold_addr", ifu_addr, model_pc);
        end
        lsu_rsp_valid = 1'b0;
        ifu_req_ready = 1'b1;
        stepClk();
        ifu_req_ready = 1'b0;
        checkOutput("iwait_ctrl", {24'h0, ctrlBits()}, 32'h40);
        for (int i = 0; i < rsp_wait; i++) begin
            stepClk();
            checkOutput("iwait_hold", {31'h0, ifu_rsp_ready}, 32'h1);
        end
        ifu_rdata     = word;
        ifu_rsp_valid = 1'b1;
        stepClk();
        ifu_rsp_valid = 1'b0;
        ifu_rdata     = ~word;
        checkOutput("exec_inst", inst, word);
        checkOutput("exec_ctrl", {24'h0, ctrlBits()}, 32'h0);
    endtask

    // From EXEC through optional memory access and WB back to FETCH
    task automatic finishInstr(input int mreq_wait, input int mrsp_wait);
        logic [31:0] exp_next;
        int          cnt;
        exp_next = modelNext(model_pc, branch, zero, less, imm, rs1_val);
        cnt      = retire_cnt;
        stepClk();
        if (mem_re || mem_we) begin
            lsu_req_ready = 1'b0;
            checkOutput("mreq_valid", {24'h0, ctrlBits()}, 32'h20);
            for (int i = 0; i < mreq_wait; i++) begin
                stepClk();
                checkOutput("mreq_hold", {31'h0, lsu_req_valid}, 32'h1);
            end
            lsu_req_ready = 1'b1;
            stepClk();
            lsu_req_ready = 1'b0;
            checkOutput("mwait_ctrl", {24'h0, ctrlBits()}, 32'h10);
            for (int i = 0; i < mrsp_wait; i++) begin
                stepClk();
                checkOutput("mwait_hold", {31'h0, lsu_rsp_ready}, 32'h1);
            end
            lsu_rsp_valid = 1'b1;
            stepClk();
            lsu_rsp_valid = 1'b0;
        end
        checkOutput("wb_strobes", {30'h0, reg_we, retire}, {30'h0, rd_we, 1'b1});
        checkOutput("wb_pc_held", pc, model_pc);
        stepClk();
        checkOutput("next_pc", pc, exp_next);
        checkOutput("next_fetch", {24'h0, ctrlBits()}, 32'h80);
        checkOutput("retire_once", retire_cnt, cnt + 1);
        model_pc = exp_next;
    endtask

    task automatic runInstr(input logic [2:0] br, input logic z, input logic l,
                            input logic [31:0] im, input logic [31:0] rs1,
                            input logic rdwe, input logic mre, input logic mwe,
                            input int req_wait, input int rsp_wait,
                            input int mreq_wait, input int mrsp_wait, input bit spurious);
        applyStimulus(br, z, l, im, rs1, rdwe, mre, mwe, 1'b0);
        doFetch(req_wait, rsp_wait, $urandom, spurious);
        finishInstr(mreq_wait, mrsp_wait);
    endtask

    task automatic jumpTo(input logic [31:0] target);
        runInstr(3'b001, 1'b0, 1'b0, target - model_pc, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic haltCase(input logic eb, input logic [2:0] br, input logic [7:0] exp_ctrl);
        logic [31:0] pc_before;
        int          cnt;
        doReset();
        applyStimulus(br, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, eb);
        doFetch(0, 0, 32'h0010_0073, 1'b0);
        pc_before = model_pc;
        cnt       = retire_cnt;
        stepClk();
        checkOutput("halt_ctrl", {24'h0, ctrlBits()}, {24'h0, exp_ctrl});
        checkOutput("halt_pc", pc, pc_before);
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepClk();
            checkOutput("halt_absorb", {24'h0, ctrlBits()}, {24'h0, exp_ctrl});
        end
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        checkOutput("halt_pc_final", pc, pc_before);
        checkOutput("halt_no_retire", retire_cnt, cnt);
    endtask

    logic [2:0]  tbl_br  [11] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b101,
                                  3'b101, 3'b110, 3'b110, 3'b111, 3'b111};
    logic        tbl_z   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        tbl_l   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] tbl_exp [11] = '{32'h8000_0104, 32'h8000_0120, 32'h0000_1020,
                                  32'h8000_0104, 32'h8000_0120, 32'h8000_0120,
                                  32'h8000_0104, 32'h8000_0104, 32'h8000_0120,
                                  32'h8000_0120, 32'h8000_0104};

    // Directed scenarios followed by a randomized instruction stream
    initial begin
        int          code;
        int          kind;
        int          cnt;
        doReset();
        checkOutput("first_addr", ifu_addr, 32'h8000_0000);
        runInstr(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        checkOutput("second_addr", ifu_addr, 32'h8000_0004);

        for (int i = 0; i < 11; i++) begin
            jumpTo(32'h8000_0100);
            runInstr(tbl_br[i], tbl_z[i], tbl_l[i], 32'h20, 32'h1001, 1'b1, 1'b0, 1'b0,
                     0, 0, 0, 0, 1'b0);
            checkOutput($sformatf("branch_tbl_%0d", i), pc, tbl_exp[i]);
        end

        runInstr(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 3, 0, 0, 5, 1'b0);
        runInstr(3'b000, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1, 3, 1, 1, 1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            code = $urandom_range(0, 6);
            if (code >= 3) code++;
            kind = $urandom_range(0, 2);
            runInstr(code[2:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom, 1'($urandom_range(0, 1)),
                     kind == 1, kind == 2,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        jumpTo(32'hFFFF_FFFC);
        runInstr(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        checkOutput("wrap_pc", pc, 32'h0000_0000);

        jumpTo(32'h8000_0200);
        applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        doFetch(0, 0, 32'h0000_2003, 1'b0);
        stepClk();
        lsu_req_ready = 1'b1;
        stepClk();
        lsu_req_ready = 1'b0;
        checkOutput("abort_in_mwait", {31'h0, lsu_rsp_ready}, 32'h1);
        cnt   = retire_cnt;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_pc", pc, RESET_PC);
        checkOutput("abort_ctrl", {24'h0, ctrlBits()}, 32'h0);
        lsu_rsp_valid = 1'b1;
        stepClk();
        stepClk();
        lsu_rsp_valid = 1'b0;
        checkOutput("abort_no_retire", retire_cnt, cnt);
        rst_n    = 1'b1;
        model_pc = RESET_PC;
        stepClk();
        runInstr(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        checkOutput("abort_recover", pc, 32'h8000_0004);

        haltCase(1'b1, 3'b000, 8'b0000_0010);
        haltCase(1'b0, 3'b011, 8'b0000_0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
